// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC, gates the PC and pipeline enables,
// and runs the IDLE / RUN / single-step / HALT-drain state machine.
module if_pc_sequencer #(
  parameter int NB_ADDR      = 32,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mode_step,
  input  logic               i_step,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_ADDR-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [NB_ADDR-1:0] i_jump_target,
  input  logic               i_halt,
  output logic [NB_ADDR-1:0] o_pc_next,
  output logic               o_pc_enable,
  output logic               o_pipe_enable,
  output logic               o_flush,
  output logic               o_running,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_cycle_count
);

  localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_STEP_WAIT = 3'd2;
  localparam logic [2:0] ST_STEP_EXEC = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [NB_DRN-1:0] drain_q, drain_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  logic active, redirect, halt_acc;

  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
  assign redirect = i_jump | i_branch_taken;
  // A HALT behind a redirect is on the wrong path; a stalled one retries later.
  assign halt_acc = active & i_halt & ~i_stall & ~redirect;

  // Stall hold is realised through o_pc_enable, so the data path shows pc+4.
  always_comb begin
    o_pc_next = i_pc + NB_ADDR'(4);
    if (i_jump)              o_pc_next = i_jump_target;
    else if (i_branch_taken) o_pc_next = i_branch_target;
  end

  assign o_pc_enable   = active & (redirect | ~i_stall) & ~halt_acc;
  assign o_flush       = active & redirect;
  assign o_pipe_enable = active | (state_q == ST_DRAIN);
  assign o_running     = active | (state_q == ST_STEP_WAIT);
  assign o_halted      = (state_q == ST_HALTED);
  assign o_cycle_count = cnt_q;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    if (o_pipe_enable) cnt_d = cnt_q + NB_CNT'(1);
    case (state_q)
      ST_IDLE:      if (i_start) state_d = i_mode_step ? ST_STEP_WAIT : ST_RUN;
      ST_RUN: begin
        if (halt_acc) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRN'(DRAIN_CYCLES - 1);
        end
      end
      ST_STEP_WAIT: if (i_step) state_d = ST_STEP_EXEC;
      ST_STEP_EXEC: begin
        state_d = ST_STEP_WAIT;
        if (halt_acc) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRN'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - NB_DRN'(1);
      end
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
